damage_fuel_manager: RTL and testbench
======================================

Name: damage_fuel_manager

Overview:
- Sits directly downstream of the collision/game-over logic.
- Consumes its per-pixel collision flags (car_collision, truck_collision, oil_collision, fuel_symbol_collision) and produces the fuelOver/healthOver inputs that feed gameOver.
- Latches collisions across each frame, applies damage, invulnerability, skid and fuel bookkeeping once per frame, and runs the game life-cycle state machine.

Parameters:
- HEALTH_MAX, 3, starting and maximum health points.
- FUEL_MAX, 100, starting and maximum fuel units; FUEL_W = $clog2(FUEL_MAX+1).
- FUEL_REFILL, 30, fuel added per fuel-symbol pickup.
- FUEL_DEC_FRAMES, 8, frames per 1-unit fuel burn.
- IFRAMES, 60, invulnerability frames after a damaging hit.
- SKID_FRAMES, 30, skid duration after oil contact.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- game_start  in  1  one-cycle start/restart request.
- car_collision  in  1  player overlaps car/boar/edge (level, per pixel).
- truck_collision  in  1  player overlaps truck (level, per pixel).
- oil_collision  in  1  player overlaps oil (level, per pixel).
- fuel_symbol_collision  in  1  player overlaps fuel symbol (level, per pixel).
- health  out  3  current health, 0..HEALTH_MAX.
- fuel  out  FUEL_W  current fuel, 0..FUEL_MAX.
- healthOver  out  1  health reached 0.
- fuelOver  out  1  fuel reached 0.
- skid  out  1  player skidding from oil; steering is locked.
- invulnerable  out  1  invulnerability window active; drives sprite blinking.
- playing  out  1  FSM in PLAYING.
- fuel_low  out  1  low-fuel warning; exists only with the optional feature, else tied 0.

Behaviour:
- Reset:
  - FSM=IDLE, health=HEALTH_MAX, fuel=FUEL_MAX.
  - healthOver=fuelOver=skid=invulnerable=playing=fuel_low=0.
  - All latches and counters cleared.
- FSM states IDLE, PLAYING, OVER:
  - IDLE --game_start--> PLAYING.
  - PLAYING --health or fuel reaches 0--> OVER.
  - OVER --game_start--> PLAYING.
  - game_start while in PLAYING is ignored.
- Entry to PLAYING (reinit):
  - health=HEALTH_MAX, fuel=FUEL_MAX.
  - Over flags, counters and latches cleared.
- Frame latches (car_l, truck_l, oil_l, fuel_l):
  - Set on any cycle the matching input is high.
  - On a startOfFrame cycle: sampled, then cleared.
  - An input high in the same cycle as startOfFrame lands in the fresh latch, i.e. it counts for the next frame.
- Frame update: applied on startOfFrame in PLAYING only; results visible the next cycle (1-cycle latency).
- Damage:
  - dmg = truck_l ? 2 : car_l ? 1 : 0.
  - If dmg>0 and inv_cnt==0: health = max(health-dmg, 0), inv_cnt = IFRAMES.
  - Otherwise inv_cnt decrements if nonzero.
  - invulnerable = (inv_cnt != 0).
- Fuel pickup:
  - Rising edge only: fuel_l && !fuel_prev (fuel_prev = previous frame's fuel_l).
  - fuel = min(fuel+FUEL_REFILL, FUEL_MAX), computed at FUEL_W+1 bits.
  - A pickup frame skips that frame's burn; the burn divider still advances.
- Fuel burn:
  - Divider counts 0..FUEL_DEC_FRAMES-1.
  - At terminal count: fuel = max(fuel-1, 0), divider wraps to 0.
- Oil:
  - If oil_l and skid_cnt==0: skid_cnt = SKID_FRAMES.
  - Oil contact while skidding does not retrigger; skid_cnt decrements otherwise.
  - skid = (skid_cnt != 0).
- End of game:
  - healthOver/fuelOver assert in the same update that produces 0 for that quantity; both may assert together.
  - In OVER, health and fuel hold; skid and invulnerable are forced 0.
- Inputs outside PLAYING: collisions are not latched. startOfFrame in IDLE/OVER has no effect.
- Reset mid-game: returns to IDLE next edge regardless of pending latches.

Optional Feature:
- Macro DFM_LOW_FUEL_WARN_EN.
- When defined: fuel_low = playing && fuel <= FUEL_MAX/4, registered and updated with the frame update.
- When undefined: fuel_low tied to 0 and no comparator logic is generated.

Decomposition:
- Package dfm_pkg holds:
  - state enum {IDLE, PLAYING, OVER};
  - CAR_DAMAGE=1 and TRUCK_DAMAGE=2;
  - a helper function for saturating add/subtract.
- Sub-module frame_countdown:
  - Loadable down-counter with load/value inputs, decrementing on startOfFrame, with a nonzero output.
  - Instantiated for the invulnerability and skid counters.

Test Plan (default parameters):
- Reset, game_start, then 8 frames with no collisions -> playing=1, health=3, fuel=99.
- car_collision for 50 cycles within one frame -> health 3->2 only once; invulnerable=1 for 60 frames; a second car hit at frame 30 is ignored; a hit at frame 61 gives health=1.
- truck_collision + car_collision with health=1 -> health=0, healthOver=1, FSM=OVER; further frames leave health/fuel frozen; game_start -> health=3, fuel=100, healthOver=0.
- fuel=90, fuel_symbol_collision held across 3 frames -> fuel=100 after one pickup (saturates), no second refill; release then re-contact -> refill applies again.
- oil_collision in frame N -> skid=1 from the cycle after startOfFrame N+1 for 30 frames; oil again at frame N+10 does not extend the skid.
- Burn fuel to 0 (drop to 1, wait 8 frames) -> fuelOver=1, playing=0. With DFM_LOW_FUEL_WARN_EN, fuel_low=1 at fuel<=25.

Source files
------------

// File: rtl/damage_fuel_manager_pkg.sv
// Shared types and helpers for the damage/fuel manager: game state encoding,
// per-hit damage amounts and a clamping add used for health and fuel.
package dfm_pkg;

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} gameState;

  localparam int CAR_DAMAGE   = 1;
  localparam int TRUCK_DAMAGE = 2;

  // Adds a signed delta and clamps the result to 0..maxValue.
  function automatic int satAdjust(input int value, input int delta, input int maxValue);
    int r;
    r = value + delta;
    if (r < 0) r = 0;
    else if (r > maxValue) r = maxValue;
    return r;
  endfunction

endpackage

// File: rtl/damage_fuel_manager_frame_countdown.sv
// Loadable per-frame down-counter; load wins over tick, and the count
// parks at zero.
module frame_countdown #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         tick,
  output logic         nonzero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)               count <= '0;
    else if (load)                    count <= loadValue;
    else if (tick && count != '0)     count <= count - W'(1);
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/damage_fuel_manager.sv
// Per-frame damage, invulnerability, skid and fuel bookkeeping plus the game
// life-cycle FSM. Optional low-fuel warning: define DFM_LOW_FUEL_WARN_EN.
module damage_fuel_manager
  import dfm_pkg::*;
#(
  parameter int HEALTH_MAX      = 3,
  parameter int FUEL_MAX        = 100,
  parameter int FUEL_REFILL     = 30,
  parameter int FUEL_DEC_FRAMES = 8,
  parameter int IFRAMES         = 60,
  parameter int SKID_FRAMES     = 30,
  parameter int FUEL_W          = $clog2(FUEL_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              game_start,
  input  logic              car_collision,
  input  logic              truck_collision,
  input  logic              oil_collision,
  input  logic              fuel_symbol_collision,
  output logic [2:0]        health,
  output logic [FUEL_W-1:0] fuel,
  output logic              healthOver,
  output logic              fuelOver,
  output logic              skid,
  output logic              invulnerable,
  output logic              playing,
  output logic              fuel_low
);

  localparam int CNT_W   = $clog2(((IFRAMES > SKID_FRAMES) ? IFRAMES : SKID_FRAMES) + 1);
  localparam int DIV_W   = $clog2(FUEL_DEC_FRAMES + 1);
  localparam int NUM_CNT = 2;
  localparam int INV     = 0;
  localparam int SKD     = 1;

  gameState state, nextState;
  logic carL, truckL, oilL, fuelL, fuelPrev;
  logic [DIV_W-1:0] divCnt;
  logic frameUpd, startReq, hit, pickup, divTerm;
  int dmg;
  logic [2:0] healthNext;
  logic [FUEL_W:0] fuelSum;
  logic [FUEL_W-1:0] fuelNext;
  logic [NUM_CNT-1:0] cntLoad, cntNz;
  logic [NUM_CNT-1:0][CNT_W-1:0] cntVal;

  always_comb begin
    frameUpd   = startOfFrame && (state == PLAYING);
    startReq   = game_start && (state != PLAYING);
    dmg        = truckL ? TRUCK_DAMAGE : (carL ? CAR_DAMAGE : 0);
    hit        = (dmg != 0) && !cntNz[INV];
    healthNext = hit ? 3'(satAdjust(int'(health), -dmg, HEALTH_MAX)) : health;
    pickup     = fuelL && !fuelPrev;
    divTerm    = (divCnt == DIV_W'(FUEL_DEC_FRAMES - 1));
    // Refill headroom is checked one bit wider so the sum cannot wrap.
    fuelSum    = {1'b0, fuel} + (FUEL_W+1)'(FUEL_REFILL);
    fuelNext   = fuel;
    if (pickup)
      fuelNext = (fuelSum > (FUEL_W+1)'(FUEL_MAX)) ? FUEL_W'(FUEL_MAX) : fuelSum[FUEL_W-1:0];
    else if (divTerm)
      fuelNext = FUEL_W'(satAdjust(int'(fuel), -1, FUEL_MAX));
    cntLoad[INV] = frameUpd && hit;
    cntLoad[SKD] = frameUpd && oilL && !cntNz[SKD];
  end

  assign cntVal = {CNT_W'(SKID_FRAMES), CNT_W'(IFRAMES)};

  for (genvar i = 0; i < NUM_CNT; i++) begin : gCnt
    frame_countdown #(.W(CNT_W)) uCnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (startReq),
      .load      (cntLoad[i]),
      .loadValue (cntVal[i]),
      .tick      (frameUpd),
      .nonzero   (cntNz[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, OVER: if (game_start) nextState = PLAYING;
      PLAYING:    if (frameUpd && (healthNext == '0 || fuelNext == '0)) nextState = OVER;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || startReq) begin
      health     <= 3'(HEALTH_MAX);
      fuel       <= FUEL_W'(FUEL_MAX);
      healthOver <= 1'b0;
      fuelOver   <= 1'b0;
      {carL, truckL, oilL, fuelL, fuelPrev} <= '0;
      divCnt     <= '0;
    end else if (state == PLAYING) begin
      if (startOfFrame) begin
        // Latches restart with this cycle's inputs; they count toward the next frame.
        carL       <= car_collision;
        truckL     <= truck_collision;
        oilL       <= oil_collision;
        fuelL      <= fuel_symbol_collision;
        fuelPrev   <= fuelL;
        divCnt     <= divTerm ? '0 : divCnt + DIV_W'(1);
        health     <= healthNext;
        fuel       <= fuelNext;
        healthOver <= (healthNext == '0);
        fuelOver   <= (fuelNext == '0);
      end else begin
        carL   <= carL   | car_collision;
        truckL <= truckL | truck_collision;
        oilL   <= oilL   | oil_collision;
        fuelL  <= fuelL  | fuel_symbol_collision;
      end
    end else begin
      {carL, truckL, oilL, fuelL} <= '0;
    end
  end

  assign playing      = (state == PLAYING);
  assign invulnerable = playing && cntNz[INV];
  assign skid         = playing && cntNz[SKD];

`ifdef DFM_LOW_FUEL_WARN_EN
  logic fuelLow;
  always_ff @(posedge clk) begin
    if (reset || startReq) fuelLow <= 1'b0;
    else if (frameUpd)     fuelLow <= (nextState == PLAYING) && (fuelNext <= FUEL_W'(FUEL_MAX / 4));
  end
  assign fuel_low = fuelLow;
`else
  assign fuel_low = 1'b0;
`endif

endmodule

// File: tb/tb_damage_fuel_manager.sv
// Self-checking bench for damage_fuel_manager: cycle-level reference model
// feeding a scoreboard, plus directed checks at the key game milestones.
module tb_damage_fuel_manager;

  localparam int HMAX = 3;
  localparam int FMAX = 100;
  localparam int REFILL = 30;
  localparam int DECF = 8;
  localparam int IFR = 60;
  localparam int SKF = 30;
  localparam int FUEL_W = 7;
`ifdef DFM_LOW_FUEL_WARN_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, startOfFrame, game_start;
  logic car_collision, truck_collision, oil_collision, fuel_symbol_collision;
  logic [2:0] health;
  logic [FUEL_W-1:0] fuel;
  logic healthOver, fuelOver, skid, invulnerable, playing, fuel_low;
  logic [15:0] dutOuts;

  always #5 clk = ~clk;

  damage_fuel_manager dut (
    .clk                   (clk),
    .reset                 (reset),
    .startOfFrame          (startOfFrame),
    .game_start            (game_start),
    .car_collision         (car_collision),
    .truck_collision       (truck_collision),
    .oil_collision         (oil_collision),
    .fuel_symbol_collision (fuel_symbol_collision),
    .health                (health),
    .fuel                  (fuel),
    .healthOver            (healthOver),
    .fuelOver              (fuelOver),
    .skid                  (skid),
    .invulnerable          (invulnerable),
    .playing               (playing),
    .fuel_low              (fuel_low)
  );

  assign dutOuts = {health, fuel, healthOver, fuelOver, skid, invulnerable, playing, fuel_low};

  int numChecks = 0;
  int numPass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got === exp) numPass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference model state (mState: 0 idle, 1 playing, 2 over)
  int mState, mHealth, mFuel, mInv, mSkid, mDiv;
  bit mCarL, mTruckL, mOilL, mFuelL, mFuelPrev, mHOver, mFOver, mLow;
  logic [15:0] expQ[$];

  task automatic modelInit();
    mHealth = HMAX; mFuel = FMAX; mInv = 0; mSkid = 0; mDiv = 0;
    {mCarL, mTruckL, mOilL, mFuelL, mFuelPrev, mHOver, mFOver, mLow} = '0;
  endtask

  task automatic modelFrame();
    int dmg, h, f;
    bit pick;
    dmg = mTruckL ? 2 : (mCarL ? 1 : 0);
    h = mHealth;
    if (dmg > 0 && mInv == 0) begin
      h = (mHealth > dmg) ? mHealth - dmg : 0;
      mInv = IFR;
    end else if (mInv > 0) mInv--;
    if (mOilL && mSkid == 0) mSkid = SKF;
    else if (mSkid > 0) mSkid--;
    pick = mFuelL && !mFuelPrev;
    mFuelPrev = mFuelL;
    f = mFuel;
    if (pick) f = (mFuel + REFILL > FMAX) ? FMAX : mFuel + REFILL;
    else if (mDiv == DECF - 1) f = (mFuel > 0) ? mFuel - 1 : 0;
    mDiv = (mDiv == DECF - 1) ? 0 : mDiv + 1;
    mHealth = h; mFuel = f;
    mHOver = (h == 0); mFOver = (f == 0);
    if (h == 0 || f == 0) mState = 2;
    mLow = (mState == 1) && (f <= FMAX / 4);
  endtask

  task automatic modelEdge(input bit rst, sof, gs, c, t, o, f);
    if (rst) begin
      modelInit(); mState = 0;
    end else if (mState != 1) begin
      if (gs) begin modelInit(); mState = 1; end
    end else if (sof) begin
      modelFrame();
      mCarL = c; mTruckL = t; mOilL = o; mFuelL = f;
    end else begin
      mCarL |= c; mTruckL |= t; mOilL |= o; mFuelL |= f;
    end
  endtask

  function automatic logic [15:0] modelOuts();
    bit play;
    play = (mState == 1);
    return {3'(mHealth), 7'(mFuel), mHOver, mFOver, play && mSkid != 0,
            play && mInv != 0, play, LOW_EN && mLow};
  endfunction

  // One clock: drive inputs, predict, then compare on the falling edge.
  task automatic cyc(input bit rst, sof, gs, c, t, o, f);
    reset = rst; startOfFrame = sof; game_start = gs;
    car_collision = c; truck_collision = t; oil_collision = o; fuel_symbol_collision = f;
    modelEdge(rst, sof, gs, c, t, o, f);
    expQ.push_back(modelOuts());
    @(posedge clk);
    @(negedge clk);
    chk("outs", dutOuts, expQ.pop_front());
  endtask

  task automatic frame(input bit c, t, o, f, input int len = 3);
    for (int i = 0; i < len; i++) cyc(0, 0, 0, c, t, o, f);
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic idleFrames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0);
  endtask

  initial begin
    {reset, startOfFrame, game_start, car_collision, truck_collision,
     oil_collision, fuel_symbol_collision} = 7'b1000000;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rstHealth", health, 3);
    chk("rstFuel", fuel, 100);
    chk("rstPlaying", playing, 0);
    chk("rstFlags", {healthOver, fuelOver, skid, invulnerable, fuel_low}, 0);

    frame(1, 1, 1, 1);
    chk("idleHealth", health, 3);
    chk("idleFuel", fuel, 100);

    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("startPlaying", playing, 1);
    idleFrames(8);
    chk("burn8Fuel", fuel, 99);
    chk("burn8Health", health, 3);

    frame(1, 0, 0, 0, 50);
    chk("carHit", health, 2);
    chk("carInv", invulnerable, 1);
    idleFrames(29);
    frame(1, 0, 0, 0);
    chk("invIgnore", health, 2);
    idleFrames(29);
    chk("invLast", invulnerable, 1);
    idleFrames(1);
    chk("invEnd", invulnerable, 0);
    frame(1, 0, 0, 0);
    chk("carHit2", health, 1);

    idleFrames(59);
    chk("inv2Last", invulnerable, 1);
    idleFrames(1);
    frame(1, 1, 0, 0);
    chk("lethalHealth", health, 0);
    chk("lethalOver", healthOver, 1);
    chk("lethalFuelOver", fuelOver, 0);
    chk("lethalPlaying", playing, 0);
    chk("lethalInv", invulnerable, 0);
    chk("lethalFuel", fuel, 84);
    idleFrames(3);
    frame(1, 1, 1, 1);
    chk("overHealth", health, 0);
    chk("overFuel", fuel, 84);
    chk("overSkid", skid, 0);

    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("restartHealth", health, 3);
    chk("restartFuel", fuel, 100);
    chk("restartOver", healthOver, 0);
    chk("restartPlaying", playing, 1);
    idleFrames(8);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("gsIgnored", fuel, 99);

    idleFrames(72);
    chk("fuelAt90", fuel, 90);
    frame(0, 0, 0, 1);
    chk("pickupSat", fuel, 100);
    frame(0, 0, 0, 1);
    frame(0, 0, 0, 1);
    chk("pickupHeld", fuel, 100);
    idleFrames(44);
    chk("fuelAt95", fuel, 95);
    frame(0, 0, 0, 1);
    chk("refillAgain", fuel, 100);
    idleFrames(7);
    chk("divAdvanced", fuel, 100);
    idleFrames(1);
    chk("burnAfterRefill", fuel, 99);

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("skidPre", skid, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("skidOn", skid, 1);
    idleFrames(9);
    frame(0, 0, 1, 0);
    idleFrames(19);
    chk("skidLast", skid, 1);
    idleFrames(1);
    chk("skidEnd", skid, 0);

    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("sofCarDeferred", health, 3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sofCarApplied", health, 2);

    cyc(0, 0, 0, 1, 1, 1, 1);
    cyc(1, 0, 0, 1, 1, 1, 1);
    chk("midRstPlaying", playing, 0);
    chk("midRstHealth", health, 3);
    chk("midRstInv", invulnerable, 0);
    frame(0, 0, 0, 0);
    chk("midRstIdleFuel", fuel, 100);

    cyc(0, 0, 1, 0, 0, 0, 0);
    idleFrames(592);
    chk("fuelAt26", fuel, 26);
    chk("lowAt26", fuel_low, 0);
    idleFrames(8);
    chk("fuelAt25", fuel, 25);
    chk("lowAt25", fuel_low, LOW_EN);
    idleFrames(192);
    chk("fuelAt1", fuel, 1);
    chk("fuelAt1Over", fuelOver, 0);
    idleFrames(7);
    chk("fuelAt1Playing", playing, 1);
    idleFrames(1);
    chk("fuelEmpty", fuel, 0);
    chk("fuelOverSet", fuelOver, 1);
    chk("fuelEmptyPlaying", playing, 0);
    chk("fuelEmptyHealthOver", healthOver, 0);
    chk("fuelEmptyLow", fuel_low, 0);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
